// File: rtl/shift_reg_universal.sv
// rtl/shift_reg_universal.sv - universal shift register with serial word capture
// Hold, shift right/left, parallel load; counts shifts and latches each completed word.
module shift_reg_universal #(
  parameter int              WIDTH = 8,
  parameter logic [WIDTH-1:0] INIT = '0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [1:0]               mode,
  input  logic                     sdi,
  input  logic [WIDTH-1:0]         pdi,
  output logic [WIDTH-1:0]         q,
  output logic                     sdo,
  output logic [WIDTH-1:0]         word,
  output logic                     word_valid,
  output logic [$clog2(WIDTH)-1:0] bit_cnt
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_SHR  = 2'b01;
  localparam logic [1:0] MODE_SHL  = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  logic [WIDTH-1:0] q_shift;
  logic             shifting;
  logic             word_done;

  always_comb begin
    q_shift = q;
    case (mode)
      MODE_SHR: q_shift = {sdi, q[WIDTH-1:1]};
      MODE_SHL: q_shift = {q[WIDTH-2:0], sdi};
      default:  q_shift = q;
    endcase
  end

  assign shifting  = (mode == MODE_SHR) || (mode == MODE_SHL);
  // The completed word includes the bit shifted in on the completing edge.
  assign word_done = shifting && (bit_cnt == LAST_BIT);

  always_ff @(posedge clk) begin
    if (reset) begin
      q          <= INIT;
      word       <= '0;
      word_valid <= 1'b0;
      bit_cnt    <= '0;
    end else begin
      word_valid <= word_done;
      case (mode)
        MODE_LOAD: begin
          q       <= pdi;
          bit_cnt <= '0;
        end
        MODE_SHR, MODE_SHL: begin
          q       <= q_shift;
          bit_cnt <= word_done ? '0 : bit_cnt + CW'(1);
          if (word_done) word <= q_shift;
        end
        MODE_HOLD: begin
        end
        default: begin
        end
      endcase
    end
  end

  assign sdo = (mode == MODE_SHR) ? q[0] : q[WIDTH-1];

endmodule

// File: tb/tb_shift_reg_universal.sv
// tb/tb_shift_reg_universal.sv - scoreboard bench for shift_reg_universal
module tb_shift_reg_universal;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, sdi, sdo, word_valid;
  logic [1:0] mode;
  logic [7:0] pdi, q, word;
  logic [2:0] bit_cnt;

  logic       reset4, sdi4, sdo4, word_valid4;
  logic [1:0] mode4;
  logic [3:0] pdi4, q4, word4;
  logic [1:0] bit_cnt4;

  shift_reg_universal #(.WIDTH(8), .INIT(8'h00)) dut8 (
    .clk(clk), .reset(reset), .mode(mode), .sdi(sdi), .pdi(pdi),
    .q(q), .sdo(sdo), .word(word), .word_valid(word_valid), .bit_cnt(bit_cnt)
  );

  shift_reg_universal #(.WIDTH(4), .INIT(4'h0)) dut4 (
    .clk(clk), .reset(reset4), .mode(mode4), .sdi(sdi4), .pdi(pdi4),
    .q(q4), .sdo(sdo4), .word(word4), .word_valid(word_valid4), .bit_cnt(bit_cnt4)
  );

  int checks = 0;
  int passes = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] w;
    int         c;
  } exp_t;
  exp_t sb8[$];
  exp_t sb4[$];
  exp_t e8, e4;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: got %0h, required %0h", name, act, req);
  endtask

  always @(negedge clk) begin
    if (word_valid === 1'b1) begin
      if (sb8.size() == 0) check("word_valid8 unexpected pulse", 32'(word_valid), 32'd0);
      else begin
        e8 = sb8.pop_front();
        check("word8 value", 32'(word), 32'(e8.w));
        check("word8 pulse cycle", cyc, e8.c);
      end
    end
  end

  always @(negedge clk) begin
    if (word_valid4 === 1'b1) begin
      if (sb4.size() == 0) check("word_valid4 unexpected pulse", 32'(word_valid4), 32'd0);
      else begin
        e4 = sb4.pop_front();
        check("word4 value", 32'(word4), 32'(e4.w));
        check("word4 pulse cycle", cyc, e4.c);
      end
    end
  end

  task automatic drive(input logic [1:0] m, input logic s);
    mode = m;
    sdi  = s;
    @(posedge clk);
    #1;
  endtask

  task automatic push8(input logic [7:0] w, input int c);
    exp_t e;
    e.w = w;
    e.c = c;
    sb8.push_back(e);
  endtask

  task automatic push4(input logic [3:0] w, input int c);
    exp_t e;
    e.w = {4'h0, w};
    e.c = c;
    sb4.push_back(e);
  endtask

  logic [7:0] seq;
  logic [7:0] piso;
  logic [3:0] exp4 [5];
  int         c1;

  initial begin
    reset = 1'b1; mode = 2'b11; pdi = 8'hFF; sdi = 1'b0;
    reset4 = 1'b1; mode4 = 2'b00; pdi4 = 4'h0; sdi4 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset q", 32'(q), 32'h00);
    check("reset word", 32'(word), 32'h00);
    check("reset word_valid", 32'(word_valid), 32'd0);
    check("reset bit_cnt", 32'(bit_cnt), 32'd0);
    reset = 1'b0;

    // Shift right: first bit ends at q[0]
    seq = 8'b1011_0010;
    for (int i = 0; i < 8; i++) begin
      if (i == 7) push8(8'h4D, cyc + 1);
      drive(2'b01, seq[7-i]);
    end
    check("shr q", 32'(q), 32'h4D);
    check("shr bit_cnt", 32'(bit_cnt), 32'd0);
    mode = 2'b01; #1;
    check("sdo mode01", 32'(sdo), 32'd1);
    mode = 2'b10; #1;
    check("sdo mode10", 32'(sdo), 32'd0);

    // Shift left, then a second back-to-back word
    for (int i = 0; i < 8; i++) begin
      if (i == 7) begin
        c1 = cyc + 1;
        push8(8'hB2, c1);
      end
      drive(2'b10, seq[7-i]);
    end
    check("shl q", 32'(q), 32'hB2);
    for (int i = 0; i < 8; i++) begin
      if (i == 7) push8(8'hFF, c1 + 8);
      drive(2'b10, 1'b1);
    end

    // PISO
    pdi = 8'hA5;
    drive(2'b11, 1'b0);
    check("load bit_cnt", 32'(bit_cnt), 32'd0);
    piso = 8'b1010_0101;
    for (int i = 0; i < 8; i++) begin
      mode = 2'b10; sdi = 1'b0; #1;
      check("piso sdo", 32'(sdo), 32'(piso[7-i]));
      if (i == 7) push8(8'h00, cyc + 1);
      @(posedge clk); #1;
    end
    check("piso q", 32'(q), 32'h00);

    // Hold stretches a word
    repeat (3) drive(2'b10, 1'b1);
    check("pre-hold bit_cnt", 32'(bit_cnt), 32'd3);
    repeat (5) drive(2'b00, 1'b1);
    check("hold bit_cnt", 32'(bit_cnt), 32'd3);
    check("hold q", 32'(q), 32'h07);
    for (int i = 0; i < 5; i++) begin
      if (i == 4) push8(8'hFF, cyc + 1);
      drive(2'b10, 1'b1);
    end

    // Load discards a partial word
    repeat (3) drive(2'b10, 1'b0);
    pdi = 8'h0F;
    drive(2'b11, 1'b0);
    check("abort load bit_cnt", 32'(bit_cnt), 32'd0);
    check("abort load word kept", 32'(word), 32'hFF);
    check("abort load q", 32'(q), 32'h0F);
    for (int i = 0; i < 8; i++) begin
      if (i == 7) push8(8'h00, cyc + 1);
      drive(2'b10, 1'b0);
      if (i == 6) check("post-load bit_cnt", 32'(bit_cnt), 32'd7);
    end

    // Reset mid-word
    repeat (5) drive(2'b10, 1'b1);
    reset = 1'b1;
    drive(2'b01, 1'b1);
    reset = 1'b0;
    check("reset mid bit_cnt", 32'(bit_cnt), 32'd0);
    check("reset mid word", 32'(word), 32'h00);
    check("reset mid q", 32'(q), 32'h00);

    // Reset on the completing edge
    for (int i = 0; i < 8; i++) begin
      if (i == 7) push8(8'hFF, cyc + 1);
      drive(2'b10, 1'b1);
    end
    repeat (7) drive(2'b10, 1'b1);
    reset = 1'b1;
    drive(2'b10, 1'b1);
    reset = 1'b0;
    check("reset complete word", 32'(word), 32'h00);
    check("reset complete bit_cnt", 32'(bit_cnt), 32'd0);
    mode = 2'b00;

    // WIDTH=4 legacy SIPO behaviour
    exp4[0] = 4'b1000; exp4[1] = 4'b0100; exp4[2] = 4'b0010;
    exp4[3] = 4'b0001; exp4[4] = 4'b0000;
    reset4 = 1'b0;
    mode4  = 2'b01;
    for (int i = 0; i < 8; i++) begin
      sdi4 = (i == 0);
      if (i == 3) push4(4'b0001, cyc + 1);
      if (i == 7) push4(4'b0000, cyc + 1);
      @(posedge clk); #1;
      if (i < 5) check("legacy q4", 32'(q4), 32'(exp4[i]));
    end
    mode4 = 2'b00;

    repeat (3) @(posedge clk);
    #1;
    check("missing word8 pulses", sb8.size(), 32'd0);
    check("missing word4 pulses", sb4.size(), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
